pixel_frame_ctrl: RTL and testbench
===================================

// Module: pixel_frame_ctrl
// PURPOSE
//  Frame-level sequencer for the pixel array. On a start request it runs one frame:
//  erase -> expose (runtime-programmable length) -> convert (ADC ramp) -> row-by-row
//  readout with a ready/valid handshake to the downstream readout logic.
//  Drives the array's erase/expose/convert/read control lines and the shared ADC ramp.
// PARAMETERS
//  C_ERASE    5    erase phase length, cycles (>=1)
//  C_CONVERT  255  convert phase length, cycles (>=1, <= 2**CNT_W-1)
//  C_READ     5    read settle length per row, cycles (>=1)
//  N_ROWS     2    rows read out sequentially (>=1)
//  CNT_W      8    width of phase counter, expose_time and adc_count
// PORTS
//  clk         in   1        clock, all logic rising-edge
//  reset       in   1        synchronous, active-high
//  start       in   1        frame request, sampled only in IDLE
//  abort       in   1        synchronous frame abort
//  expose_time in   CNT_W    exposure length in cycles, latched on accepted start
//  rd_ready    in   1        downstream accepts current row
//  erase       out  1        pixel erase
//  expose      out  1        pixel expose
//  convert     out  1        pixel convert
//  read        out  N_ROWS   one-hot row read select
//  adc_count   out  CNT_W    ADC ramp / data code shared with array
//  row_valid   out  1        current row data stable; row index = onehot(read)
//  busy        out  1        high in every state except IDLE
//  frame_done  out  1        one-cycle pulse at frame completion
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; latched exposure 0; row index 0. Reset
//    mid-frame forces this at the next edge; no frame_done.
//  - All outputs decoded from registers only; no input-to-output combinational path.
//  - States: IDLE, ERASE, EXPOSE, CONVERT, READ.
//  - IDLE: start=1 at edge k -> ERASE from cycle k+1; expose_time latched at edge k
//    (value 0 treated as 1). start while busy ignored (not queued).
//  - ERASE: erase=1 exactly C_ERASE cycles -> EXPOSE.
//  - EXPOSE: expose=1 exactly latched-exposure cycles -> CONVERT.
//  - CONVERT: convert=1 exactly C_CONVERT cycles; adc_count=0 on first convert cycle,
//    +1 each cycle, ends at C_CONVERT-1; no wrap. adc_count holds its final value
//    through READ and IDLE; cleared to 0 on entering ERASE.
//  - READ: row r (0..N_ROWS-1 ascending) has read[r]=1; after C_READ cycles
//    row_valid=1 and held (read[r] held) until rd_ready=1. Transfer = row_valid&rd_ready;
//    next cycle row r+1 starts fresh C_READ count, row_valid=0. rd_ready outside
//    row_valid ignored. Transfer of last row -> IDLE, frame_done=1 the following cycle
//    (first IDLE cycle), busy=0 that cycle.
//  - Phase boundary: exactly one of erase/expose/convert/read active per busy cycle,
//    never overlapping, no gap cycles between phases.
//  - abort=1 in any busy state -> IDLE next edge, all controls 0, no frame_done;
//    abort in IDLE ignored. abort and start same cycle in IDLE: abort wins (stay IDLE).
//  - abort and reset have priority over every other transition; reset over abort.
// STRUCTURE
//  - Package pixel_ctrl_pkg: state enum (IDLE, ERASE, EXPOSE, CONVERT, READ) and
//    phase-length defaults shared with PIXEL_STATE and the readout block.
//  - One sub-module: phase_counter (CNT_W down-counter, load value, load strobe,
//    done flag when count reaches 1), reused for every timed phase.
//  - Row index: $clog2(N_ROWS)-bit counter; read = one-hot decode, gated by READ.
// TESTING
//  1 reset held 3 cycles -> all outputs 0, busy=0; release, no start -> stays IDLE.
//  2 expose_time=10, start 1 cycle, rd_ready=1 -> erase 5, expose 10, convert 255
//    cycles, adc_count 0..254, read[0] 6 cycles, read[1] 6 cycles, frame_done 1 pulse;
//    total busy = 5+10+255+12 = 282 cycles.
//  3 expose_time=0 -> expose lasts 1 cycle; change expose_time mid-frame -> no effect.
//  4 rd_ready=0 for 20 cycles at row 0 -> row_valid and read[0] held 20 cycles,
//    adc_count stable, then transfer and row 1 proceeds normally.
//  5 abort in EXPOSE, and separately reset in CONVERT -> IDLE next cycle, controls 0,
//    no frame_done; new start then runs a full correct frame.
//  6 start pulsed while busy and start+abort together in IDLE -> ignored, frame
//    count unchanged; back-to-back start on frame_done cycle accepted, ERASE next.

Source files
------------

// File: rtl/pixel_ctrl_pkg.sv
// Shared types and phase-length defaults for the pixel frame sequencer.
package pixel_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ERASE   = 3'd1,
    ST_EXPOSE  = 3'd2,
    ST_CONVERT = 3'd3,
    ST_READ    = 3'd4
  } state_e;

  localparam int C_ERASE_DEF   = 5;
  localparam int C_CONVERT_DEF = 255;
  localparam int C_READ_DEF    = 5;
  localparam int N_ROWS_DEF    = 2;
  localparam int CNT_W_DEF     = 8;

  // Row index width; a single-row array still needs one bit of index.
  function automatic int row_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_frame_ctrl_phase_counter.sv
// Down-counter timing one phase: load the phase length, done while count is 1.
module phase_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load wins; otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/pixel_frame_ctrl.sv
// Frame sequencer: erase -> expose -> convert (ADC ramp) -> row readout.
// Row handshake: a row transfers on a cycle where row_valid && rd_ready;
// row_valid stays high (with its read line) until that happens, and
// rd_ready is ignored while row_valid is low.
module pixel_frame_ctrl
  import pixel_ctrl_pkg::*;
#(
  parameter int C_ERASE   = C_ERASE_DEF,
  parameter int C_CONVERT = C_CONVERT_DEF,
  parameter int C_READ    = C_READ_DEF,
  parameter int N_ROWS    = N_ROWS_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  expose_time,
  input  logic              rd_ready,
  output logic              erase,
  output logic              expose,
  output logic              convert,
  output logic [N_ROWS-1:0] read,
  output logic [CNT_W-1:0]  adc_count,
  output logic              row_valid,
  output logic              busy,
  output logic              frame_done
);

  localparam int ROW_W = row_w(N_ROWS);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_ROWS - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  exp_q, exp_d;
  logic [CNT_W-1:0]  adc_q, adc_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              erase_q, erase_d;
  logic              expose_q, expose_d;
  logic              convert_q, convert_d;
  logic              busy_q, busy_d;
  logic [N_ROWS-1:0] read_q, read_d;

  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_done;

  phase_counter #(.CNT_W(CNT_W)) u_phase_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .done     (cnt_done)
  );

  // Next-state, phase-counter loads and registered output decode.
  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    adc_d    = adc_q;
    row_d    = row_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = '0;

    if (abort && (state_q != ST_IDLE)) begin
      // Abort drops straight to idle; the ADC code is left as it was.
      state_d = ST_IDLE;
      row_d   = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            state_d  = ST_ERASE;
            exp_d    = (expose_time == '0) ? CNT_W'(1) : expose_time;
            adc_d    = '0;
            row_d    = '0;
            valid_d  = 1'b0;
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(C_ERASE);
          end
        end
        ST_ERASE: begin
          if (cnt_done) begin
            state_d  = ST_EXPOSE;
            cnt_load = 1'b1;
            cnt_val  = exp_q;
          end
        end
        ST_EXPOSE: begin
          if (cnt_done) begin
            state_d  = ST_CONVERT;
            adc_d    = '0;
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(C_CONVERT);
          end
        end
        ST_CONVERT: begin
          if (cnt_done) begin
            // Ramp stops on its last code and holds it for readout.
            state_d  = ST_READ;
            row_d    = '0;
            valid_d  = 1'b0;
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(C_READ);
          end else begin
            adc_d = adc_q + CNT_W'(1);
          end
        end
        ST_READ: begin
          if (!valid_q) begin
            if (cnt_done) begin
              valid_d = 1'b1;
            end
          end else if (rd_ready) begin
            valid_d = 1'b0;
            if (row_q == LAST_ROW) begin
              state_d = ST_IDLE;
              row_d   = '0;
              done_d  = 1'b1;
            end else begin
              row_d    = row_q + ROW_W'(1);
              cnt_load = 1'b1;
              cnt_val  = CNT_W'(C_READ);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          row_d   = '0;
          valid_d = 1'b0;
        end
      endcase
    end

    erase_d   = (state_d == ST_ERASE);
    expose_d  = (state_d == ST_EXPOSE);
    convert_d = (state_d == ST_CONVERT);
    busy_d    = (state_d != ST_IDLE);
    read_d    = (state_d == ST_READ) ? (N_ROWS'(1) << row_d) : '0;
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      exp_q     <= '0;
      adc_q     <= '0;
      row_q     <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      erase_q   <= 1'b0;
      expose_q  <= 1'b0;
      convert_q <= 1'b0;
      busy_q    <= 1'b0;
      read_q    <= '0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      adc_q     <= adc_d;
      row_q     <= row_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      erase_q   <= erase_d;
      expose_q  <= expose_d;
      convert_q <= convert_d;
      busy_q    <= busy_d;
      read_q    <= read_d;
    end
  end

  assign erase      = erase_q;
  assign expose     = expose_q;
  assign convert    = convert_q;
  assign read       = read_q;
  assign adc_count  = adc_q;
  assign row_valid  = valid_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_pixel_frame_ctrl.sv
// Bench for pixel_frame_ctrl: timeline reference model, per-scenario tasks.
module tb_pixel_frame_ctrl;

  localparam int CNT_W  = 8;
  localparam int N_ROWS = 2;
  localparam int C_E    = 5;
  localparam int C_C    = 255;
  localparam int C_R    = 5;
  localparam int VW     = 6 + N_ROWS + CNT_W;
  localparam int GUARD  = 3000;
  // Bit positions in the packed output vector.
  localparam int FD_B = CNT_W;
  localparam int BY_B = CNT_W + 1;
  localparam int RV_B = CNT_W + 2;
  localparam int CV_B = CNT_W + 3 + N_ROWS;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset, start, abort, rd_ready;
  logic [CNT_W-1:0] expose_time;
  logic erase, expose, convert, row_valid, busy, frame_done;
  logic [N_ROWS-1:0] read;
  logic [CNT_W-1:0] adc_count;
  logic [VW-1:0] dut_vec;

  always #5 clk = ~clk;

  pixel_frame_ctrl #(
    .C_ERASE(C_E), .C_CONVERT(C_C), .C_READ(C_R), .N_ROWS(N_ROWS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .expose_time(expose_time), .rd_ready(rd_ready),
    .erase(erase), .expose(expose), .convert(convert), .read(read),
    .adc_count(adc_count), .row_valid(row_valid), .busy(busy), .frame_done(frame_done)
  );

  assign dut_vec = {erase, expose, convert, read, row_valid, busy, frame_done, adc_count};

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  // A frame is a timeline measured from its first erase cycle (m_t = 0):
  // erase [0,C_E), expose [C_E,C_E+E), convert for C_C cycles, then rows.
  bit m_active = 1'b0;
  bit m_fdone  = 1'b0;
  int m_t, m_e, m_row, m_row_start;
  int m_adc = 0;

  function automatic logic [VW-1:0] exp_vec();
    logic e_er, e_ex, e_cv, e_rv;
    logic [N_ROWS-1:0] e_rd;
    logic [CNT_W-1:0] e_adc;
    int t_cv, t_rd;
    e_er = 1'b0; e_ex = 1'b0; e_cv = 1'b0; e_rv = 1'b0; e_rd = '0;
    e_adc = CNT_W'(m_adc);
    t_cv = C_E + m_e;
    t_rd = t_cv + C_C;
    if (m_active) begin
      if (m_t < C_E) e_er = 1'b1;
      else if (m_t < t_cv) e_ex = 1'b1;
      else if (m_t < t_rd) begin
        e_cv = 1'b1;
        e_adc = CNT_W'(m_t - t_cv);
      end else begin
        e_rd[m_row] = 1'b1;
        e_rv = ((m_t - m_row_start) >= C_R);
      end
    end
    return {e_er, e_ex, e_cv, e_rd, e_rv, m_active, m_fdone, e_adc};
  endfunction

  task automatic model_tick(input logic s, input logic a, input logic r, input logic rs,
                            input logic [CNT_W-1:0] et);
    logic [VW-1:0] cur;
    cur = exp_vec();
    if (rs) begin
      m_active = 1'b0; m_fdone = 1'b0; m_adc = 0;
    end else begin
      m_fdone = 1'b0;
      if (m_active) begin
        if (cur[CV_B]) m_adc = int'(cur[CNT_W-1:0]);
        if (a) m_active = 1'b0;
        else begin
          if (cur[RV_B] && r) begin
            if (m_row == N_ROWS - 1) begin
              m_active = 1'b0; m_fdone = 1'b1;
            end else begin
              m_row++; m_row_start = m_t + 1;
            end
          end
          m_t++;
        end
      end else if (s && !a) begin
        m_active = 1'b1; m_t = 0;
        m_e = (et == '0) ? 1 : int'(et);
        m_row = 0; m_row_start = C_E + m_e + C_C; m_adc = 0;
      end
    end
  endtask

  // ---------------- driver ----------------
  // Inputs are changed 1 time unit after a rising edge; the model samples
  // the same values as the DUT at the edge.
  task automatic step();
    @(posedge clk);
    model_tick(start, abort, rd_ready, reset, expose_time);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dut_vec !== '0) begin
        failures++; $display("FAIL reset_outputs got=%h exp=%h", dut_vec, {VW{1'b0}});
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("FAIL reset_idle got=%h exp=%h", dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_nominal();
    int busy_n = 0, fd_n = 0, g = 0;
    expose_time = 8'd10; rd_ready = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    while (m_active && g < GUARD) begin
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("FAIL nominal_cycle t=%0t got=%h exp=%h", $time, dut_vec, exp_vec());
      end
      if (busy) busy_n++;
      if (frame_done) fd_n++;
      step(); g++;
    end
    checks++;
    if (dut_vec !== exp_vec()) begin
      failures++; $display("FAIL nominal_done got=%h exp=%h", dut_vec, exp_vec());
    end
    if (frame_done) fd_n++;
    checks++;
    if (g >= GUARD) begin failures++; $display("FAIL nominal_timeout got=%0d exp<%0d", g, GUARD); end
    checks++;
    if (busy_n != 282) begin failures++; $display("FAIL nominal_busy_cycles got=%0d exp=282", busy_n); end
    checks++;
    if (fd_n != 1) begin failures++; $display("FAIL nominal_frame_done got=%0d exp=1", fd_n); end
    checks++;
    if (adc_count !== 8'd254) begin failures++; $display("FAIL nominal_adc_hold got=%0d exp=254", adc_count); end
    step();
  endtask

  task automatic test_zero_expose();
    int ex_n = 0, g = 0;
    expose_time = '0; start = 1'b1;
    step(); start = 1'b0;
    while (m_active && g < GUARD) begin
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("FAIL zero_expose_cycle t=%0t got=%h exp=%h", $time, dut_vec, exp_vec());
      end
      if (expose) ex_n++;
      expose_time = CNT_W'($urandom_range(0, 255));
      rd_ready = 1'($urandom_range(0, 1));
      step(); g++;
    end
    checks++;
    if (ex_n != 1 || g >= GUARD) begin
      failures++; $display("FAIL zero_expose_len got=%0d exp=1 (g=%0d)", ex_n, g);
    end
    rd_ready = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    int hold = 0, v0_n = 0, g = 0;
    logic [VW-1:0] ev;
    expose_time = CNT_W'($urandom_range(1, 20)); start = 1'b1; rd_ready = 1'b0;
    step(); start = 1'b0;
    while (m_active && g < GUARD) begin
      ev = exp_vec();
      checks++;
      if (dut_vec !== ev) begin
        failures++; $display("FAIL backpressure_cycle t=%0t got=%h exp=%h", $time, dut_vec, ev);
      end
      if (row_valid && read[0]) v0_n++;
      if (ev[RV_B] && m_row == 0 && hold < 20) begin
        rd_ready = 1'b0; hold++;
      end else if (ev[RV_B]) rd_ready = 1'b1;
      else rd_ready = 1'($urandom_range(0, 1));
      step(); g++;
    end
    checks++;
    if (v0_n != 21) begin failures++; $display("FAIL backpressure_row0_valid got=%0d exp=21", v0_n); end
    rd_ready = 1'b0;
    step();
  endtask

  task automatic test_abort_reset();
    int g;
    // abort during expose
    expose_time = CNT_W'($urandom_range(4, 30)); start = 1'b1;
    step(); start = 1'b0;
    while (m_t < C_E + 2) step();
    abort = 1'b1; step(); abort = 1'b0;
    checks++;
    if (dut_vec[VW-1:CNT_W] !== '0 || dut_vec !== exp_vec()) begin
      failures++; $display("FAIL abort_expose got=%h exp=%h", dut_vec, exp_vec());
    end
    step();
    checks++;
    if (frame_done !== 1'b0) begin failures++; $display("FAIL abort_no_done got=%b exp=0", frame_done); end
    // full frame after abort, then reset during convert, then another frame
    for (int f = 0; f < 2; f++) begin
      expose_time = CNT_W'($urandom_range(0, 30)); start = 1'b1;
      step(); start = 1'b0; g = 0;
      while (m_active && g < GUARD) begin
        checks++;
        if (dut_vec !== exp_vec()) begin
          failures++; $display("FAIL abort_reset_frame%0d t=%0t got=%h exp=%h", f, $time, dut_vec, exp_vec());
        end
        rd_ready = 1'($urandom_range(0, 1));
        step(); g++;
      end
      checks++;
      if (frame_done !== 1'b1 || g >= GUARD) begin
        failures++; $display("FAIL abort_reset_frame%0d_done got=%b exp=1", f, frame_done);
      end
      step();
      if (f == 0) begin
        expose_time = 8'd3; start = 1'b1;
        step(); start = 1'b0;
        while (m_t < C_E + m_e + 10) step();
        reset = 1'b1; step(); reset = 1'b0;
        checks++;
        if (dut_vec !== '0) begin failures++; $display("FAIL reset_convert got=%h exp=0", dut_vec); end
        step();
      end
    end
  endtask

  task automatic test_ignored_start();
    int fd_n = 0, g = 0;
    expose_time = 8'd5; start = 1'b1; rd_ready = 1'b1;
    step(); start = 1'b0;
    while (m_active && g < GUARD) begin
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("FAIL busy_start_cycle t=%0t got=%h exp=%h", $time, dut_vec, exp_vec());
      end
      if (frame_done) fd_n++;
      start = 1'($urandom_range(0, 3) == 0);
      step(); g++;
    end
    start = 1'b0;
    if (frame_done) fd_n++;
    // back-to-back: start on the frame_done cycle
    expose_time = 8'd3; start = 1'b1;
    step(); start = 1'b0;
    checks++;
    if (erase !== 1'b1 || dut_vec !== exp_vec()) begin
      failures++; $display("FAIL back_to_back_erase got=%h exp=%h", dut_vec, exp_vec());
    end
    g = 0;
    while (m_active && g < GUARD) begin
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("FAIL back_to_back_cycle t=%0t got=%h exp=%h", $time, dut_vec, exp_vec());
      end
      step(); g++;
    end
    if (frame_done) fd_n++;
    step();
    checks++;
    if (fd_n != 2) begin failures++; $display("FAIL busy_start_frames got=%0d exp=2", fd_n); end
    // start together with abort in idle
    start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || dut_vec !== exp_vec()) begin
      failures++; $display("FAIL start_abort_idle got=%h exp=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    int g;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < int'($urandom_range(0, 5)); i++) step();
      expose_time = CNT_W'($urandom_range(0, 40)); start = 1'b1;
      step(); start = 1'b0; g = 0;
      while (m_active && g < GUARD) begin
        checks++;
        if (dut_vec !== exp_vec()) begin
          failures++; $display("FAIL random_frame%0d t=%0t got=%h exp=%h", f, $time, dut_vec, exp_vec());
        end
        rd_ready = 1'($urandom_range(0, 1));
        start = 1'($urandom_range(0, 7) == 0);
        step(); g++;
      end
      start = 1'b0;
      checks++;
      if (dut_vec !== exp_vec() || g >= GUARD) begin
        failures++; $display("FAIL random_done%0d got=%h exp=%h", f, dut_vec, exp_vec());
      end
      step();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; rd_ready = 1'b0; expose_time = '0;
    test_reset();
    test_nominal();
    test_zero_expose();
    test_backpressure();
    test_abort_reset();
    test_ignored_start();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
